bp_cce_branch_predict_pc: RTL and testbench
===========================================

// Module: bp_cce_branch_predict_pc
// PURPOSE
//  CCE microcode PC generator with dynamic branch prediction and execute-stage resolution.
//  - Holds the fetch PC and predicts each branch from a table of 2-bit saturating counters (BHT).
//  - Resolves branches in execute with six compare modes, including signed compares.
//  - On a mispredict: redirects the PC, then trains the BHT.
//  - Sits between the CCE instruction RAM (fetch/predecode) and the execute stage.
// PARAMETERS
//  width_p         16  operand width for compares
//  cce_pc_width_p   8  microcode PC width
//  bht_entries_p   16  BHT depth; power of two, 2..2^cce_pc_width_p
//  reset_pc_p       0  PC value loaded on reset
// PORTS
//  clk_i               in   1               clock
//  reset_n_i           in   1               asynchronous, active-low reset
//  stall_i             in   1               hold fetch PC
//  fetch_pc_o          out  cce_pc_width_p  current fetch PC (registered)
//  fetch_pred_taken_o  out  1               prediction for the instruction at fetch_pc_o
//  pd_branch_i         in   1               instruction at fetch_pc_o is a branch (comb. from inst RAM)
//  pd_target_i         in   cce_pc_width_p  its branch target
//  ex_v_i              in   1               execute-stage instruction valid
//  ex_branch_i         in   1               execute instruction is a branch
//  ex_op_i             in   3               0 eq, 1 neq, 2 ltu, 3 leu, 4 lts, 5 les; 6,7 never taken
//  ex_opd_a_i          in   width_p         operand a
//  ex_opd_b_i          in   width_p         operand b
//  ex_pc_i             in   cce_pc_width_p  PC of the execute instruction
//  ex_target_i         in   cce_pc_width_p  branch target of the execute instruction
//  ex_pred_taken_i     in   1               prediction carried down from fetch
//  branch_res_o        out  1               resolved taken (comb.) = ex_v_i & ex_branch_i & cmp
//  mispredict_o        out  1               comb. = ex_v_i & ex_branch_i & (cmp != ex_pred_taken_i)
//  stat_branch_o       out  32              resolved-branch count (feature macro only)
//  stat_mispred_o      out  32              mispredict count (feature macro only)
// BEHAVIOUR
//  - Reset (async, reset_n_i=0):
//    - fetch_pc_o = reset_pc_p.
//    - All BHT counters = 2'b01 (weakly not-taken); fetch_pred_taken_o = 0.
//    - Stats counters = 0.
//    - A reset mid-operation discards all training.
//  - Prediction: idx = fetch_pc_o[log2(bht_entries_p)-1:0]; pred = pd_branch_i & bht[idx][1].
//    - fetch_pred_taken_o = pred.
//  - Next PC, priority order, registered on posedge clk_i:
//    1. mispredict_o: PC <= branch_res_o ? ex_target_i : ex_pc_i+1. Beats stall_i.
//    2. stall_i: PC held.
//    3. pred: PC <= pd_target_i.
//    4. otherwise: PC <= fetch_pc_o+1.
//  - PC arithmetic is modulo 2^cce_pc_width_p; 2^w-1 wraps to 0.
//  - Compare:
//    - ltu/leu are unsigned on width_p bits.
//    - lts/les are two's-complement signed.
//    - le = lt | eq.
//  - Training: on ex_v_i & ex_branch_i, bht[ex_pc_i idx] +1 if taken, -1 if not.
//    - Counters saturate at 3 and 0.
//    - Non-branch or invalid execute instructions do not train.
//  - Same-cycle read and write of the same BHT index: prediction uses the pre-update value.
//    - The new value is visible the next cycle.
//  - Latency:
//    - Resolve/mispredict outputs are combinational in the execute cycle.
//    - The redirect appears on fetch_pc_o one cycle later.
//    - Upstream squashes the wrong-path instruction in that cycle.
//  - ex_branch_i=0 with ex_v_i=1: branch_res_o=0, mispredict_o=0 regardless of ex_pred_taken_i.
// CONFIGURATION
//  - BP_CCE_BRANCH_STATS_EN defined:
//    - stat_branch_o counts each resolved branch (ex_v_i & ex_branch_i).
//    - stat_mispred_o counts each mispredict_o.
//    - Both 32-bit, wrap at 2^32, cleared by reset.
//  - BP_CCE_BRANCH_STATS_EN undefined: both ports are present and tied to 0; no counter flops.
// TESTING
//  - Reset, pd_branch_i=0, no stall, 4 cycles -> fetch_pc_o 0,1,2,3; fetch_pred_taken_o=0.
//  - First execute of branch at PC 5, target 20, beq a=b=7, pred 0:
//    -> branch_res_o=1, mispredict_o=1; next cycle fetch_pc_o=20; bht[5]=2.
//    Next fetch of PC 5 with pd_branch_i=1 -> pred 1, fetch_pc_o next=20.
//  - lts a=16'hFFFF, b=16'h0001 -> taken.
//    ltu with the same operands -> not taken.
//    les a=b=16'h8000 -> taken.
//  - bht[3]=3, then taken branch at PC 3 -> stays 3.
//    Four not-taken branches at PC 3 -> 2,1,0,0.
//  - fetch_pc_o=255 (w=8), no branch -> 0.
//    Mispredict with stall_i=1 -> PC redirects (stall ignored).
//  - STATS_EN: 10 branches, 3 mispredicts -> stat_branch_o=10, stat_mispred_o=3.
//    Assert reset_n_i mid-run -> both 0 asynchronously, PC=reset_pc_p.

Source files
------------

// File: rtl/bp_cce_branch_predict_pc_if.sv
// Fetch/predecode/execute bundle for the CCE microcode PC generator.
// master: upstream side (inst RAM, execute stage); slave: the PC generator.
interface bp_cce_branch_predict_pc_if #(
  parameter int width_p        = 16,
  parameter int cce_pc_width_p = 8
);
  logic                      stall_i;
  logic [cce_pc_width_p-1:0] fetch_pc_o;
  logic                      fetch_pred_taken_o;
  logic                      pd_branch_i;
  logic [cce_pc_width_p-1:0] pd_target_i;
  logic                      ex_v_i;
  logic                      ex_branch_i;
  logic [2:0]                ex_op_i;
  logic [width_p-1:0]        ex_opd_a_i;
  logic [width_p-1:0]        ex_opd_b_i;
  logic [cce_pc_width_p-1:0] ex_pc_i;
  logic [cce_pc_width_p-1:0] ex_target_i;
  logic                      ex_pred_taken_i;
  logic                      branch_res_o;
  logic                      mispredict_o;
  logic [31:0]               stat_branch_o;
  logic [31:0]               stat_mispred_o;

  modport master (
    output stall_i, pd_branch_i, pd_target_i, ex_v_i, ex_branch_i, ex_op_i,
           ex_opd_a_i, ex_opd_b_i, ex_pc_i, ex_target_i, ex_pred_taken_i,
    input  fetch_pc_o, fetch_pred_taken_o, branch_res_o, mispredict_o,
           stat_branch_o, stat_mispred_o
  );

  modport slave (
    input  stall_i, pd_branch_i, pd_target_i, ex_v_i, ex_branch_i, ex_op_i,
           ex_opd_a_i, ex_opd_b_i, ex_pc_i, ex_target_i, ex_pred_taken_i,
    output fetch_pc_o, fetch_pred_taken_o, branch_res_o, mispredict_o,
           stat_branch_o, stat_mispred_o
  );
endinterface

// File: rtl/bp_cce_branch_predict_pc.sv
// CCE microcode PC generator: BHT-based branch prediction at fetch,
// branch resolution and redirect/training at execute.
// Optional branch statistics counters: define BP_CCE_BRANCH_STATS_EN.

// One 2-bit saturating BHT counter.
module bp_cce_bht_ctr (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [1:0] ctr_o
);
  // Saturating up/down count; reset to weakly not-taken.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                     ctr_o <= 2'b01;
    else if (inc_i && ctr_o != 2'b11)   ctr_o <= ctr_o + 2'b01;
    else if (dec_i && ctr_o != 2'b00)   ctr_o <= ctr_o - 2'b01;
  end
endmodule

module bp_cce_branch_predict_pc #(
  parameter int                      width_p        = 16,
  parameter int                      cce_pc_width_p = 8,
  parameter int                      bht_entries_p  = 16,
  parameter logic [cce_pc_width_p-1:0] reset_pc_p   = '0
) (
  input logic                        clk_i,
  input logic                        reset_n_i,
  bp_cce_branch_predict_pc_if.slave  bus
);
  localparam int idx_w = $clog2(bht_entries_p);

  logic [cce_pc_width_p-1:0]          pc_r;
  logic [bht_entries_p-1:0][1:0]      bht;
  logic [idx_w-1:0]                   fetch_idx, ex_idx;
  logic                               pred;
  logic                               eq, ltu, lts, cmp;
  logic                               resolved, mispred;

  assign fetch_idx = pc_r[idx_w-1:0];
  assign ex_idx    = bus.ex_pc_i[idx_w-1:0];

  // Prediction reads the pre-update counter; training lands next cycle.
  assign pred = bus.pd_branch_i & bht[fetch_idx][1];

  assign eq  = (bus.ex_opd_a_i == bus.ex_opd_b_i);
  assign ltu = (bus.ex_opd_a_i <  bus.ex_opd_b_i);
  assign lts = ($signed(bus.ex_opd_a_i) < $signed(bus.ex_opd_b_i));

  // Branch condition by compare mode; codes 6 and 7 never take.
  always_comb begin
    cmp = 1'b0;
    case (bus.ex_op_i)
      3'd0:    cmp = eq;
      3'd1:    cmp = ~eq;
      3'd2:    cmp = ltu;
      3'd3:    cmp = ltu | eq;
      3'd4:    cmp = lts;
      3'd5:    cmp = lts | eq;
      default: cmp = 1'b0;
    endcase
  end

  assign resolved = bus.ex_v_i & bus.ex_branch_i;
  assign mispred  = resolved & (cmp != bus.ex_pred_taken_i);

  // Per-entry counters; only the entry addressed by the execute PC trains.
  for (genvar e = 0; e < bht_entries_p; e++) begin : g_bht
    logic hit;
    assign hit = resolved & (ex_idx == idx_w'(e));
    bp_cce_bht_ctr u_ctr (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .inc_i    (hit & cmp),
      .dec_i    (hit & ~cmp),
      .ctr_o    (bht[e])
    );
  end

  // Next fetch PC: redirect beats stall, stall beats predicted-taken.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)         pc_r <= reset_pc_p;
    else if (mispred)       pc_r <= cmp ? bus.ex_target_i
                                        : bus.ex_pc_i + cce_pc_width_p'(1);
    else if (bus.stall_i)   pc_r <= pc_r;
    else if (pred)          pc_r <= bus.pd_target_i;
    else                    pc_r <= pc_r + cce_pc_width_p'(1);
  end

  assign bus.fetch_pc_o         = pc_r;
  assign bus.fetch_pred_taken_o = pred;
  assign bus.branch_res_o       = resolved & cmp;
  assign bus.mispredict_o       = mispred;

`ifdef BP_CCE_BRANCH_STATS_EN
  logic [31:0] n_branch, n_mispred;

  // Resolved-branch and mispredict counters, wrapping at 2^32.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      n_branch  <= '0;
      n_mispred <= '0;
    end else begin
      if (resolved) n_branch  <= n_branch + 32'd1;
      if (mispred)  n_mispred <= n_mispred + 32'd1;
    end
  end

  assign bus.stat_branch_o  = n_branch;
  assign bus.stat_mispred_o = n_mispred;
`else
  assign bus.stat_branch_o  = '0;
  assign bus.stat_mispred_o = '0;
`endif
endmodule

// File: tb/tb_bp_cce_branch_predict_pc.sv
// Randomised + directed bench for bp_cce_branch_predict_pc with an
// abstract reference model (integer PC, integer counter array).
module tb_bp_cce_branch_predict_pc;
  localparam int W  = 16;
  localparam int PW = 8;
  localparam int N  = 16;
`ifdef BP_CCE_BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_cce_branch_predict_pc_if #(.width_p(W), .cce_pc_width_p(PW)) bus ();

  bp_cce_branch_predict_pc #(
    .width_p(W), .cce_pc_width_p(PW), .bht_entries_p(N), .reset_pc_p(8'd0)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_pc;
  int m_bht [N];
  longint m_sb, m_sm;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Branch condition straight from the compare-mode table.
  function automatic bit ref_cmp(input int op, input int a, input int b);
    case (op)
      0: return a == b;
      1: return a != b;
      2: return a < b;
      3: return a <= b;
      4: return sx(a) < sx(b);
      5: return sx(a) <= sx(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < N; i++) m_bht[i] = 1;
    m_sb = 0;
    m_sm = 0;
  endtask

  task automatic drive(input bit st, input bit pdb, input int pdt, input bit exv,
                       input bit exb, input int op, input int a, input int b,
                       input int expc, input int tgt, input bit expred);
    bus.stall_i         = st;
    bus.pd_branch_i     = pdb;
    bus.pd_target_i     = PW'(pdt);
    bus.ex_v_i          = exv;
    bus.ex_branch_i     = exb;
    bus.ex_op_i         = 3'(op);
    bus.ex_opd_a_i      = W'(a);
    bus.ex_opd_b_i      = W'(b);
    bus.ex_pc_i         = PW'(expc);
    bus.ex_target_i     = PW'(tgt);
    bus.ex_pred_taken_i = expred;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: check DUT against model mid-cycle, advance model, cross the edge.
  task automatic cycle();
    bit pred, resolved, c, res, mis;
    int idx;
    @(negedge clk);
    pred     = bus.pd_branch_i && (m_bht[m_pc % N] >= 2);
    resolved = bus.ex_v_i && bus.ex_branch_i;
    c        = ref_cmp(int'(bus.ex_op_i), int'(bus.ex_opd_a_i), int'(bus.ex_opd_b_i));
    res      = resolved && c;
    mis      = resolved && (c != bus.ex_pred_taken_i);
    chk("fetch_pc", bus.fetch_pc_o, m_pc);
    chk("pred_taken", bus.fetch_pred_taken_o, pred);
    chk("branch_res", bus.branch_res_o, res);
    chk("mispredict", bus.mispredict_o, mis);
    chk("stat_branch", bus.stat_branch_o, STATS ? (m_sb % 64'h1_0000_0000) : 0);
    chk("stat_mispred", bus.stat_mispred_o, STATS ? (m_sm % 64'h1_0000_0000) : 0);
    if (mis)              m_pc = res ? int'(bus.ex_target_i) : (int'(bus.ex_pc_i) + 1) % 256;
    else if (bus.stall_i) m_pc = m_pc;
    else if (pred)        m_pc = int'(bus.pd_target_i);
    else                  m_pc = (m_pc + 1) % 256;
    if (resolved) begin
      idx = int'(bus.ex_pc_i) % N;
      if (c && m_bht[idx] < 3) m_bht[idx]++;
      else if (!c && m_bht[idx] > 0) m_bht[idx]--;
      m_sb++;
    end
    if (mis) m_sm++;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_opd();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 65535));
      1: return 32'h8000;
      2: return 32'hFFFF;
      default: return int'($urandom_range(0, 2));
    endcase
  endfunction

  task automatic rnd_cycle();
    int a, b;
    a = pick_opd();
    b = ($urandom_range(0, 3) == 0) ? a : pick_opd();
    drive($urandom_range(0, 4) == 0, 1'($urandom), int'($urandom_range(0, 255)),
          $urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 7)), a, b,
          int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), 1'($urandom));
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle();
    bus.pd_branch_i = 1'b1;
    bus.stall_i     = 1'b1;
    #2;
    chk("reset_pc", bus.fetch_pc_o, 0);
    chk("reset_pred", bus.fetch_pred_taken_o, 0);
    chk("reset_stat_b", bus.stat_branch_o, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sequential fetch from reset.
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("seq_pc", bus.fetch_pc_o, i);
      cycle();
    end
    idle();
    cycle();                                   // pc 4 -> 5
    // First execute of beq at PC 5, taken, predicted not-taken.
    drive(0, 0, 0, 1, 1, 0, 7, 7, 5, 20, 0);
    #1;
    chk("beq_res", bus.branch_res_o, 1);
    chk("beq_mis", bus.mispredict_o, 1);
    cycle();
    chk("redirect_pc", bus.fetch_pc_o, 20);
    chk("bht5_model", m_bht[5], 2);
    // Not-taken mispredict at PC 4 sends fetch to 5.
    drive(0, 0, 0, 1, 1, 0, 1, 2, 4, 99, 1);
    cycle();
    chk("nt_redirect", bus.fetch_pc_o, 5);
    drive(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pc5_pred", bus.fetch_pred_taken_o, 1);
    cycle();
    chk("pred_target", bus.fetch_pc_o, 20);

    // Signed vs unsigned compares (predicted correctly to avoid redirects).
    drive(0, 0, 0, 1, 1, 4, 16'hFFFF, 16'h0001, 9, 30, 1);
    #1 chk("lts_taken", bus.branch_res_o, 1);
    cycle();
    drive(0, 0, 0, 1, 1, 2, 16'hFFFF, 16'h0001, 9, 30, 0);
    #1 chk("ltu_not", bus.branch_res_o, 0);
    cycle();
    drive(0, 0, 0, 1, 1, 5, 16'h8000, 16'h8000, 9, 30, 1);
    #1 chk("les_eq", bus.branch_res_o, 1);
    cycle();

    // Saturation at PC 3.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1, 0, 4, 4, 3, 40, 1);
      cycle();
    end
    chk("bht3_sat_hi", m_bht[3], 3);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 0, 4, 5, 3, 40, 0);
      cycle();
      chk("bht3_down", m_bht[3], (i < 3) ? 2 - i : 0);
    end

    // PC wrap and stall/mispredict priority.
    drive(0, 0, 0, 1, 1, 0, 1, 1, 10, 255, 0);
    cycle();
    chk("pc_255", bus.fetch_pc_o, 255);
    idle();
    cycle();
    chk("pc_wrap", bus.fetch_pc_o, 0);
    drive(1, 0, 0, 1, 1, 0, 1, 1, 10, 100, 0);
    cycle();
    chk("stall_redirect", bus.fetch_pc_o, 100);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("stall_hold", bus.fetch_pc_o, 100);

    // Random traffic.
    for (int i = 0; i < 2000; i++) rnd_cycle();

    // Asynchronous reset mid-cycle discards everything.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", bus.fetch_pc_o, 0);
    chk("async_pred", bus.fetch_pred_taken_o, 0);
    chk("async_stat_b", bus.stat_branch_o, 0);
    chk("async_stat_m", bus.stat_mispred_o, 0);
    model_reset();
    bus.stall_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ten resolved branches, the first three mispredicted.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 1, 0, 2, 2, 7, 50, i >= 3);
      cycle();
    end
    chk("stat10_b", bus.stat_branch_o, STATS ? 10 : 0);
    chk("stat3_m", bus.stat_mispred_o, STATS ? 3 : 0);

    for (int i = 0; i < 300; i++) rnd_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
